// File: rtl/stage5_ctrl_pkg.sv
// stage5_ctrl_pkg: shared encodings for the stage-5 control FSM.
//   state_t  : FSM state codes (also exported on State for debug)
//   OP_*     : opcode values in IROut[15:12]
//   DST1_* / DST2_* : memory port read-destination selects
//   MD_*     : write-data mux select
//   ctrl_t   : full datapath control vector
//   exCycles : number of EX states an opcode needs (0..3)
//   isLegal  : opcode is implemented
package stage5_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_LATCH  = 4'd2,
    S_DECODE = 4'd3,
    S_EXA    = 4'd4,
    S_EXB    = 4'd5,
    S_EXC    = 4'd6,
    S_HALT   = 4'd7
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_PUSHI = 4'h1;
  localparam logic [3:0] OP_POP   = 4'h2;
  localparam logic [3:0] OP_LD    = 4'h3;
  localparam logic [3:0] OP_JPOP  = 4'h4;
  localparam logic [3:0] OP_BR    = 4'h5;
  localparam logic [3:0] OP_BZ    = 4'h6;
  localparam logic [3:0] OP_CALL  = 4'h7;
  localparam logic [3:0] OP_RET   = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] DST1_IR       = 2'b00; // IR   <- Mem[PC]
  localparam logic [1:0] DST1_VALB_MSP = 2'b01; // ValB <- Mem[MSP]
  localparam logic [1:0] DST1_VALB_A   = 2'b10; // ValB <- Mem[ValA]
  localparam logic [1:0] DST2_MAIN     = 2'b00; // ValA <- main stack top
  localparam logic [1:0] DST2_RET      = 2'b01; // ValA <- return stack top

  localparam logic [2:0] MD_VALA = 3'd0;
  localparam logic [2:0] MD_VALB = 3'd1;
  localparam logic [2:0] MD_PC   = 3'd2;
  localparam logic [2:0] MD_ZEXT = 3'd3;
  localparam logic [2:0] MD_SEXT = 3'd4;
  localparam logic [2:0] MD_RES  = 3'd5;

  typedef struct packed {
    logic       pcWrite;
    logic       pcSource;
    logic       pcAdd;
    logic       mspWrite;
    logic       mspPop;
    logic       rspWrite;
    logic       rspPop;
    logic       irWrite;
    logic       valAWrite;
    logic       valBWrite;
    logic       memRead1;
    logic       memRead2;
    logic       memWrite1;
    logic       memWrite2;
    logic [1:0] memDst1;
    logic [1:0] memDst2;
    logic [2:0] memData;
    logic       instrDone;
  } ctrl_t;

  function automatic logic [1:0] exCycles(input logic [3:0] op);
    case (op)
      OP_PUSHI, OP_POP, OP_JPOP, OP_BR, OP_BZ: exCycles = 2'd1;
      OP_CALL:                                 exCycles = 2'd2;
      OP_LD, OP_RET:                           exCycles = 2'd3;
      default:                                 exCycles = 2'd0;
    endcase
  endfunction

  function automatic logic isLegal(input logic [3:0] op);
    isLegal = (op <= OP_RET) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/stage5_ctrl_decode.sv
// stage5_ctrl_decode: combinational map from (state, opcode, ValA==0) to the
// datapath control vector. Anything not explicitly raised stays 0.
//   state     in  current FSM state
//   opcode    in  IROut[15:12]
//   valAZero  in  ValAOut == 0, used only by BZ
//   ctrl      out control vector
// Macro STAGE5_CTRL_TRAP_EN: illegal opcodes get no InstrDone (they trap).
module stage5_ctrl_decode
  import stage5_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       valAZero,
  output ctrl_t      ctrl
);

  logic [1:0] nEx;
  logic       lastEx;
  logic       decodeDone;

  assign nEx    = exCycles(opcode);
  assign lastEx = ((state == S_EXA) && (nEx == 2'd1)) ||
                  ((state == S_EXB) && (nEx == 2'd2)) ||
                  ((state == S_EXC) && (nEx == 2'd3));

  // Zero-EX opcodes finish in DECODE, except HALT (and trapped illegals).
`ifdef STAGE5_CTRL_TRAP_EN
  assign decodeDone = (nEx == 2'd0) && (opcode != OP_HALT) && isLegal(opcode);
`else
  assign decodeDone = (nEx == 2'd0) && (opcode != OP_HALT);
`endif

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        // PC <- PC+1, IR read and stack-top peek issued together
        ctrl.pcWrite  = 1'b1;
        ctrl.memRead1 = 1'b1;
        ctrl.memDst1  = DST1_IR;
        ctrl.memRead2 = 1'b1;
        ctrl.memDst2  = DST2_MAIN;
      end
      S_LATCH: begin
        ctrl.irWrite   = 1'b1;
        ctrl.valAWrite = 1'b1;
      end
      S_DECODE: ctrl.instrDone = decodeDone;
      S_EXA: begin
        case (opcode)
          OP_PUSHI: begin
            ctrl.memWrite1 = 1'b1;
            ctrl.memData   = MD_ZEXT;
            ctrl.mspWrite  = 1'b1;
          end
          OP_POP: begin
            ctrl.mspWrite = 1'b1;
            ctrl.mspPop   = 1'b1;
          end
          OP_LD: begin
            ctrl.memRead1 = 1'b1;
            ctrl.memDst1  = DST1_VALB_A;
          end
          OP_JPOP: begin
            ctrl.pcWrite  = 1'b1;
            ctrl.pcSource = 1'b1;
            ctrl.mspWrite = 1'b1;
            ctrl.mspPop   = 1'b1;
          end
          OP_BR: begin
            ctrl.pcWrite = 1'b1;
            ctrl.pcAdd   = 1'b1;
          end
          OP_BZ: begin
            // pop always; branch only when the popped value is zero
            ctrl.mspWrite = 1'b1;
            ctrl.mspPop   = 1'b1;
            ctrl.pcWrite  = valAZero;
            ctrl.pcAdd    = valAZero;
          end
          OP_CALL: begin
            ctrl.memWrite2 = 1'b1;
            ctrl.memData   = MD_PC;
            ctrl.rspWrite  = 1'b1;
          end
          OP_RET: begin
            ctrl.memRead2 = 1'b1;
            ctrl.memDst2  = DST2_RET;
          end
          default: ;
        endcase
        ctrl.instrDone = lastEx;
      end
      S_EXB: begin
        case (opcode)
          OP_LD: ctrl.valBWrite = 1'b1;
          OP_CALL: begin
            ctrl.pcWrite = 1'b1;
            ctrl.pcAdd   = 1'b1;
          end
          OP_RET: begin
            ctrl.valAWrite = 1'b1;
            ctrl.rspWrite  = 1'b1;
            ctrl.rspPop    = 1'b1;
          end
          default: ;
        endcase
        ctrl.instrDone = lastEx;
      end
      S_EXC: begin
        case (opcode)
          OP_LD: begin
            ctrl.memWrite1 = 1'b1;
            ctrl.memData   = MD_VALB;
          end
          OP_RET: begin
            ctrl.pcWrite  = 1'b1;
            ctrl.pcSource = 1'b1;
          end
          default: ;
        endcase
        ctrl.instrDone = lastEx;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stage5_control.sv
// stage5_control: multi-cycle sequencer for the stage-5 stack datapath.
// Each instruction runs FETCH, LATCH, DECODE, then 0-3 EX states.
// Strobes are decoded from the state register, so Reset clears them at once.
//   CLK, Reset       clock, async active-high reset
//   Run              allow a new instruction to start
//   IROut, ValAOut   instruction and ValA fed back from the datapath
//   PC*/MSP*/RSP*/IRWrite/ValAWrite/ValBWrite/Mem*  datapath strobes
//   InstrDone        pulse in the final cycle of an instruction
//   Halted, Illegal  HALT state, sticky illegal-opcode flag
//   State            current state code
// Macro STAGE5_CTRL_TRAP_EN: illegal opcodes set Illegal and halt;
// otherwise they run as NOP and Illegal is tied low.
module stage5_control
  import stage5_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Run,
  input  logic [15:0] IROut,
  input  logic [15:0] ValAOut,
  output logic        PCWrite,
  output logic        PCSource,
  output logic        PCAdd,
  output logic        MSPWrite,
  output logic        MSPPop,
  output logic        RSPWrite,
  output logic        RSPPop,
  output logic        IRWrite,
  output logic        ValAWrite,
  output logic        ValBWrite,
  output logic        MemRead1,
  output logic        MemRead2,
  output logic        MemWrite1,
  output logic        MemWrite2,
  output logic [1:0]  MemDst1,
  output logic [1:0]  MemDst2,
  output logic [2:0]  MemData,
  output logic        InstrDone,
  output logic        Halted,
  output logic        Illegal,
  output logic [3:0]  State
);

  state_t     state;
  state_t     endState;
  ctrl_t      ctrl;
  logic [3:0] opcode;
  logic [1:0] nEx;
  logic       unusedImm;

  assign opcode    = IROut[15:12];
  assign unusedImm = ^IROut[11:0];  // immediate is consumed by the datapath only
  assign nEx       = exCycles(opcode);
  // Run is only looked at when an instruction finishes
  assign endState  = Run ? S_FETCH : S_IDLE;

`ifdef STAGE5_CTRL_TRAP_EN
  logic illegalQ;
  assign Illegal = illegalQ;
`else
  assign Illegal = 1'b0;
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
`ifdef STAGE5_CTRL_TRAP_EN
      illegalQ <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE:   if (Run) state <= S_FETCH;
        S_FETCH:  state <= S_LATCH;
        S_LATCH:  state <= S_DECODE;
        S_DECODE: begin
          if (opcode == OP_HALT)  state <= S_HALT;
`ifdef STAGE5_CTRL_TRAP_EN
          else if (!isLegal(opcode)) begin
            state    <= S_HALT;
            illegalQ <= 1'b1;
          end
`endif
          else if (nEx == 2'd0)   state <= endState;
          else                    state <= S_EXA;
        end
        S_EXA:    state <= (nEx == 2'd1) ? endState : S_EXB;
        S_EXB:    state <= (nEx == 2'd2) ? endState : S_EXC;
        S_EXC:    state <= endState;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end

  stage5_ctrl_decode uDecode (
    .state    (state),
    .opcode   (opcode),
    .valAZero (ValAOut == 16'h0000),
    .ctrl     (ctrl)
  );

  assign PCWrite   = ctrl.pcWrite;
  assign PCSource  = ctrl.pcSource;
  assign PCAdd     = ctrl.pcAdd;
  assign MSPWrite  = ctrl.mspWrite;
  assign MSPPop    = ctrl.mspPop;
  assign RSPWrite  = ctrl.rspWrite;
  assign RSPPop    = ctrl.rspPop;
  assign IRWrite   = ctrl.irWrite;
  assign ValAWrite = ctrl.valAWrite;
  assign ValBWrite = ctrl.valBWrite;
  assign MemRead1  = ctrl.memRead1;
  assign MemRead2  = ctrl.memRead2;
  assign MemWrite1 = ctrl.memWrite1;
  assign MemWrite2 = ctrl.memWrite2;
  assign MemDst1   = ctrl.memDst1;
  assign MemDst2   = ctrl.memDst2;
  assign MemData   = ctrl.memData;
  assign InstrDone = ctrl.instrDone;
  assign Halted    = (state == S_HALT);
  assign State     = state;

endmodule

// File: tb/tb_stage5_control.sv
// tb_stage5_control: directed checks of the stage-5 control FSM.
// Outputs are packed into a 22-bit vector and compared cycle by cycle
// against hand-written expected vectors, one task per scenario.
module tb_stage5_control;

  logic        CLK = 1'b0;
  logic        Reset, Run;
  logic [15:0] IROut, ValAOut;
  logic        PCWrite, PCSource, PCAdd, MSPWrite, MSPPop, RSPWrite, RSPPop;
  logic        IRWrite, ValAWrite, ValBWrite;
  logic        MemRead1, MemRead2, MemWrite1, MemWrite2;
  logic [1:0]  MemDst1, MemDst2;
  logic [2:0]  MemData;
  logic        InstrDone, Halted, Illegal;
  logic [3:0]  State;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  stage5_control dut (
    .CLK(CLK), .Reset(Reset), .Run(Run), .IROut(IROut), .ValAOut(ValAOut),
    .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd),
    .MSPWrite(MSPWrite), .MSPPop(MSPPop), .RSPWrite(RSPWrite), .RSPPop(RSPPop),
    .IRWrite(IRWrite), .ValAWrite(ValAWrite), .ValBWrite(ValBWrite),
    .MemRead1(MemRead1), .MemRead2(MemRead2), .MemWrite1(MemWrite1),
    .MemWrite2(MemWrite2), .MemDst1(MemDst1), .MemDst2(MemDst2),
    .MemData(MemData), .InstrDone(InstrDone), .Halted(Halted),
    .Illegal(Illegal), .State(State)
  );

  wire [21:0] ctl = {PCWrite, PCSource, PCAdd, MSPWrite, MSPPop, RSPWrite, RSPPop,
                     IRWrite, ValAWrite, ValBWrite, MemRead1, MemRead2,
                     MemWrite1, MemWrite2, MemDst1, MemDst2, MemData, InstrDone};

  localparam logic [21:0] B_PCW  = 22'd1 << 21;
  localparam logic [21:0] B_PCS  = 22'd1 << 20;
  localparam logic [21:0] B_PCA  = 22'd1 << 19;
  localparam logic [21:0] B_MSPW = 22'd1 << 18;
  localparam logic [21:0] B_MSPP = 22'd1 << 17;
  localparam logic [21:0] B_RSPW = 22'd1 << 16;
  localparam logic [21:0] B_RSPP = 22'd1 << 15;
  localparam logic [21:0] B_IRW  = 22'd1 << 14;
  localparam logic [21:0] B_VAW  = 22'd1 << 13;
  localparam logic [21:0] B_VBW  = 22'd1 << 12;
  localparam logic [21:0] B_MR1  = 22'd1 << 11;
  localparam logic [21:0] B_MR2  = 22'd1 << 10;
  localparam logic [21:0] B_MW1  = 22'd1 << 9;
  localparam logic [21:0] B_MW2  = 22'd1 << 8;
  localparam logic [21:0] B_DONE = 22'd1;
  localparam logic [21:0] C_FETCH = B_PCW | B_MR1 | B_MR2;
  localparam logic [21:0] C_LATCH = B_IRW | B_VAW;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Run = 1'b0; IROut = 16'h0000; ValAOut = 16'h0000;
    #2;
    checks++;
    if (State !== 4'd0 || ctl !== 22'd0 || Halted !== 1'b0 || Illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset: state %0d ctl %h halted %b illegal %b, want 0 0 0 0",
               State, ctl, Halted, Illegal);
    end
    step; step;
    Reset = 1'b0;
    step;
    checks++;
    if (State !== 4'd0 || ctl !== 22'd0) begin
      errors++;
      $display("FAIL idle_norun: state %0d ctl %h, want 0 0", State, ctl);
    end
  endtask

  task automatic test_nop;
    logic [3:0]  es [3];
    logic [21:0] ec [3];
    es = '{4'd1, 4'd2, 4'd3};
    ec = '{C_FETCH, C_LATCH, B_DONE};
    Run = 1'b1; IROut = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      step;
      checks++;
      if (State !== es[i%3] || ctl !== ec[i%3]) begin
        errors++;
        $display("FAIL nop[%0d]: state %0d ctl %h, want %0d %h", i, State, ctl, es[i%3], ec[i%3]);
      end
    end
  endtask

  task automatic test_pushi;
    logic [3:0]  es [4];
    logic [21:0] ec [4];
    es = '{4'd1, 4'd2, 4'd3, 4'd4};
    ec = '{C_FETCH, C_LATCH, 22'd0, B_MW1 | (22'd3 << 1) | B_MSPW | B_DONE};
    for (int i = 0; i < 4; i++) begin
      step;
      if (i == 0) IROut = 16'h1005;
      checks++;
      if (State !== es[i] || ctl !== ec[i]) begin
        errors++;
        $display("FAIL pushi[%0d]: state %0d ctl %h, want %0d %h", i, State, ctl, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_bz;
    logic [3:0]  es [4];
    logic [21:0] ec [4];
    es = '{4'd1, 4'd2, 4'd3, 4'd4};
    for (int j = 0; j < 2; j++) begin
      ec = '{C_FETCH, C_LATCH, 22'd0, 22'd0};
      ec[3] = (j == 0) ? (B_MSPW | B_MSPP | B_PCW | B_PCA | B_DONE)
                       : (B_MSPW | B_MSPP | B_DONE);
      for (int i = 0; i < 4; i++) begin
        step;
        if (i == 0) begin
          IROut = 16'h6003;
          ValAOut = (j == 0) ? 16'h0000 : 16'h0007;
        end
        checks++;
        if (State !== es[i] || ctl !== ec[i]) begin
          errors++;
          $display("FAIL bz%0d[%0d]: state %0d ctl %h, want %0d %h", j, i, State, ctl, es[i], ec[i]);
        end
      end
    end
    ValAOut = 16'h0000;
  endtask

  task automatic test_branch;
    logic [3:0]  es [4];
    logic [21:0] ec [4];
    es = '{4'd1, 4'd2, 4'd3, 4'd4};
    for (int j = 0; j < 2; j++) begin
      ec = '{C_FETCH, C_LATCH, 22'd0, 22'd0};
      ec[3] = (j == 0) ? (B_PCW | B_PCA | B_DONE)
                       : (B_PCW | B_PCS | B_MSPW | B_MSPP | B_DONE);
      for (int i = 0; i < 4; i++) begin
        step;
        if (i == 0) IROut = (j == 0) ? 16'h5003 : 16'h4000;
        checks++;
        if (State !== es[i] || ctl !== ec[i]) begin
          errors++;
          $display("FAIL branch%0d[%0d]: state %0d ctl %h, want %0d %h", j, i, State, ctl, es[i], ec[i]);
        end
      end
    end
  endtask

  task automatic test_call;
    logic [3:0]  es [5];
    logic [21:0] ec [5];
    es = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    ec = '{C_FETCH, C_LATCH, 22'd0, B_MW2 | (22'd2 << 1) | B_RSPW,
           B_PCW | B_PCA | B_DONE};
    for (int i = 0; i < 5; i++) begin
      step;
      if (i == 0) IROut = 16'h7010;
      checks++;
      if (State !== es[i] || ctl !== ec[i]) begin
        errors++;
        $display("FAIL call[%0d]: state %0d ctl %h, want %0d %h", i, State, ctl, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_ret;
    logic [3:0]  es [6];
    logic [21:0] ec [6];
    es = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    ec = '{C_FETCH, C_LATCH, 22'd0, B_MR2 | (22'd1 << 4),
           B_VAW | B_RSPW | B_RSPP, B_PCW | B_PCS | B_DONE};
    for (int i = 0; i < 6; i++) begin
      step;
      if (i == 0) IROut = 16'h8000;
      checks++;
      if (State !== es[i] || ctl !== ec[i]) begin
        errors++;
        $display("FAIL ret[%0d]: state %0d ctl %h, want %0d %h", i, State, ctl, es[i], ec[i]);
      end
    end
  endtask

  // POP with Run dropped mid-instruction: it completes, then idles
  // until Run returns, then a second POP runs to completion.
  task automatic test_run;
    logic [3:0]  es [10];
    logic [21:0] ec [10];
    es = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    ec = '{C_FETCH, C_LATCH, 22'd0, B_MSPW | B_MSPP | B_DONE, 22'd0, 22'd0,
           C_FETCH, C_LATCH, 22'd0, B_MSPW | B_MSPP | B_DONE};
    for (int i = 0; i < 10; i++) begin
      step;
      if (i == 0) IROut = 16'h2000;
      if (i == 1) Run = 1'b0;
      if (i == 5) Run = 1'b1;
      checks++;
      if (State !== es[i] || ctl !== ec[i]) begin
        errors++;
        $display("FAIL run[%0d]: state %0d ctl %h, want %0d %h", i, State, ctl, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_ld_reset;
    logic [3:0]  es [6];
    logic [21:0] ec [6];
    es = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    ec = '{C_FETCH, C_LATCH, 22'd0, B_MR1 | (22'd2 << 6), B_VBW,
           B_MW1 | (22'd1 << 1) | B_DONE};
    for (int i = 0; i < 5; i++) begin
      step;
      if (i == 0) IROut = 16'h3000;
      checks++;
      if (State !== es[i] || ctl !== ec[i]) begin
        errors++;
        $display("FAIL ld[%0d]: state %0d ctl %h, want %0d %h", i, State, ctl, es[i], ec[i]);
      end
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (State !== 4'd0 || ctl !== 22'd0) begin
      errors++;
      $display("FAIL ld_reset_async: state %0d ctl %h, want 0 0", State, ctl);
    end
    step;
    Reset = 1'b0;
    checks++;
    if (State !== 4'd0 || ctl !== 22'd0) begin
      errors++;
      $display("FAIL ld_reset_hold: state %0d ctl %h, want 0 0", State, ctl);
    end
    for (int i = 0; i < 6; i++) begin
      step;
      checks++;
      if (State !== es[i] || ctl !== ec[i]) begin
        errors++;
        $display("FAIL ld_after[%0d]: state %0d ctl %h, want %0d %h", i, State, ctl, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_halt;
    logic [3:0]  es [6];
    es = '{4'd1, 4'd2, 4'd3, 4'd7, 4'd7, 4'd7};
    for (int i = 0; i < 6; i++) begin
      step;
      if (i == 0) IROut = 16'hF000;
      checks++;
      if (State !== es[i] || (i > 1 && ctl !== 22'd0) || Halted !== (i > 2)) begin
        errors++;
        $display("FAIL halt[%0d]: state %0d ctl %h halted %b, want %0d", i, State, ctl, Halted, es[i]);
      end
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (State !== 4'd0 || Halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: state %0d halted %b, want 0 0", State, Halted);
    end
    step;
    Reset = 1'b0;
  endtask

  task automatic test_illegal;
`ifdef STAGE5_CTRL_TRAP_EN
    logic [3:0]  es [5];
    logic [21:0] ec [5];
    es = '{4'd1, 4'd2, 4'd3, 4'd7, 4'd7};
    ec = '{C_FETCH, C_LATCH, 22'd0, 22'd0, 22'd0};
    for (int i = 0; i < 5; i++) begin
      step;
      if (i == 0) IROut = 16'hA000;
      checks++;
      if (State !== es[i] || ctl !== ec[i]) begin
        errors++;
        $display("FAIL illegal[%0d]: state %0d ctl %h, want %0d %h", i, State, ctl, es[i], ec[i]);
      end
    end
    checks++;
    if (Illegal !== 1'b1 || Halted !== 1'b1) begin
      errors++;
      $display("FAIL illegal_flag: illegal %b halted %b, want 1 1", Illegal, Halted);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (Illegal !== 1'b0 || State !== 4'd0) begin
      errors++;
      $display("FAIL illegal_reset: illegal %b state %0d, want 0 0", Illegal, State);
    end
    step;
    Reset = 1'b0;
`else
    logic [3:0]  es [4];
    logic [21:0] ec [4];
    es = '{4'd1, 4'd2, 4'd3, 4'd1};
    ec = '{C_FETCH, C_LATCH, B_DONE, C_FETCH};
    for (int i = 0; i < 4; i++) begin
      step;
      if (i == 0) IROut = 16'hA000;
      checks++;
      if (State !== es[i] || ctl !== ec[i] || Illegal !== 1'b0) begin
        errors++;
        $display("FAIL illegal[%0d]: state %0d ctl %h illegal %b, want %0d %h 0",
                 i, State, ctl, Illegal, es[i], ec[i]);
      end
    end
`endif
  endtask

  initial begin
    test_reset;
    test_nop;
    test_pushi;
    test_bz;
    test_branch;
    test_call;
    test_ret;
    test_run;
    test_ld_reset;
    test_halt;
    test_illegal;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage5_control.md
# stage5_control

Multi-cycle control FSM that sequences the stage-5 stack datapath: PC, IR, ValA, ValB, main stack pointer (MSP), return stack pointer (RSP) and the dual-port memory.
- Reads IROut and ValAOut back from the datapath.
- Drives every datapath control strobe, so each instruction executes as a fixed sequence: fetch, latch, decode, 0–3 execute cycles.
- Sits directly above the stage-5 datapath and replaces bench-driven control.

## Interface
Parameters: none; encodings come from the shared package.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Run  in  1  permits starting a new instruction.
- IROut  in  16  current instruction; [15:12] opcode, [11:0] immediate.
- ValAOut  in  16  ValA register; tested by BZ.
- PCWrite, PCSource, PCAdd  out  1 each  PC control.
- MSPWrite, MSPPop, RSPWrite, RSPPop  out  1 each  stack pointer control; Pop=0 means push (increment).
- IRWrite, ValAWrite, ValBWrite  out  1 each  register load enables.
- MemRead1, MemRead2, MemWrite1, MemWrite2  out  1 each  memory port strobes.
- MemDst1  out  2  port-1 read destination: 00 IR←Mem[PC], 01 ValB←Mem[MSP], 10 ValB←Mem[ValA].
- MemDst2  out  2  port-2 read destination: 00 ValA←MainStack top, 01 ValA←ReturnStack top.
- MemData  out  3  write-data select: 0 ValA, 1 ValB, 2 PC, 3 ZeroExt, 4 SignExt, 5 Res.
- InstrDone  out  1  one-cycle pulse in the last cycle of each instruction.
- Halted  out  1  FSM is in HALT.
- Illegal  out  1  sticky illegal-opcode flag.
- State  out  4  current state code, for debug.

## Operation
States: IDLE, FETCH, LATCH, DECODE, EXA, EXB, EXC, HALT.
- Outputs are Moore-decoded from the state and IROut[15:12]. BZ additionally uses ValAOut.
- Every strobe not listed for a state is 0.

Common sequence:
- IDLE: all strobes 0. Run=1 → FETCH.
- FETCH: PCWrite=1, PCAdd=0, PCSource=0 (PC←PC+1); MemRead1=1, MemDst1=00; MemRead2=1, MemDst2=00. The stack top is peeked; MSP is unchanged. → LATCH.
- LATCH: IRWrite=1, ValAWrite=1. → DECODE.
- DECODE: no strobes. Next state depends on opcode.

Opcodes (execute cycles):
- 0 NOP: DECODE is last → FETCH.
- 1 PUSHI: EXA: MemWrite1=1, MemData=3, MSPWrite=1, MSPPop=0.
- 2 POP: EXA: MSPWrite=1, MSPPop=1.
- 3 LD (replace top with Mem[top]):
  - EXA: MemRead1=1, MemDst1=10.
  - EXB: ValBWrite=1.
  - EXC: MemWrite1=1, MemData=1.
- 4 JPOP: EXA: PCWrite=1, PCSource=1, MSPWrite=1, MSPPop=1.
- 5 BR: EXA: PCWrite=1, PCAdd=1 (PC←PC+SignExt).
- 6 BZ: EXA: MSPWrite=1, MSPPop=1; PCWrite=1, PCAdd=1 only when ValAOut==0.
- 7 CALL:
  - EXA: MemWrite2=1, MemData=2, RSPWrite=1, RSPPop=0.
  - EXB: PCWrite=1, PCAdd=1.
- 8 RET:
  - EXA: MemRead2=1, MemDst2=01.
  - EXB: ValAWrite=1, RSPWrite=1, RSPPop=1.
  - EXC: PCWrite=1, PCSource=1.
- F HALT: DECODE → HALT. HALT is left only by Reset.
- 9–E: illegal; see Configuration.

Run handling:
- At the end of an instruction: Run=1 → FETCH; Run=0 → IDLE.
- Run is ignored mid-instruction.

Offsets are relative to the already-incremented PC, i.e. the address of the instruction plus 1. The FSM performs no arithmetic itself.

## Timing
- Reset asserted at any time: state→IDLE and every output 0 immediately, including Illegal. A partial instruction is abandoned.
- Instruction length in cycles, FETCH to last:
  - 3: NOP.
  - 4: PUSHI, POP, JPOP, BR, BZ.
  - 5: CALL.
  - 6: LD, RET.
- InstrDone is high in the last cycle: DECODE for NOP, otherwise the last EX state.
- Memory reads have one-cycle latency: a read is issued in cycle N and its destination register loads in cycle N+1.
- Back-to-back instructions have zero gap: the last EX cycle is followed directly by FETCH.
- BZ samples ValAOut combinationally during EXA. ValA is stable there because it was loaded in LATCH.

## Configuration
Macro `STAGE5_CTRL_TRAP_EN`:
- Defined: an illegal opcode in DECODE sets Illegal=1 and goes to HALT. Halted=1 and InstrDone=0.
- Undefined: an illegal opcode executes as NOP (InstrDone in DECODE). Illegal is tied to 0.

## Structure
- Package stage5_ctrl_pkg holds:
  - the state enum;
  - opcode constants OP_NOP..OP_HALT;
  - MemDst and MemData encodings;
  - the EX-cycle count per opcode.
- One sub-module, stage5_ctrl_decode: purely combinational, mapping (state, opcode, ValAOut==0) to the control vector.
- The top module holds the state register, next-state logic and the Illegal flag.

## Test plan
- Reset, then Run=1 with IROut=16'h0000: FETCH/LATCH/DECODE repeat. The PCWrite pulse appears every 3 cycles and InstrDone every 3 cycles.
- IROut=16'h1005 (PUSHI 5): EXA shows MemWrite1=1, MemData=3, MSPWrite=1, MSPPop=0. InstrDone is in cycle 4.
- IROut=16'h6003 (BZ): with ValAOut=0, EXA has PCWrite=1, PCAdd=1, MSPPop=1. With ValAOut=7, PCWrite=0 and the pop is still asserted.
- IROut=16'h8000 (RET): EXA MemRead2 with MemDst2=01; EXB ValAWrite with RSPPop=1; EXC PCWrite with PCSource=1. InstrDone is in cycle 6.
- IROut=16'hA000:
  - trap build: Illegal=1, Halted=1, all strobes 0 until Reset.
  - no-trap build: InstrDone in DECODE, then FETCH.
- Reset asserted during EXB of LD: outputs 0 in the same cycle, State=IDLE. After release, FETCH starts on the first edge with Run=1.
